lcd_sched: RTL and testbench
============================

# lcd_sched

Sequencer and two-port arbiter for the HD44780-class character LCD on the 4-bit bus. After reset it runs the power-on delay and the full controller init sequence. It then grants byte-write requests (command or character) from two requesters, for example the sensor-readout formatter and the status/alarm writer. Each granted byte is serialized as two enable-strobed nibbles with the required settle delays. All timing is derived from the single system clock, so no divided FSM clock is needed.

## Interface
Parameters:
- EN_HIGH, 12: cycles enable_out is held high per nibble (1 µs @ 12 MHz)
- NIB_GAP, 12: cycles enable_out is held low after each nibble strobe
- CMD_WAIT, 600: post-byte wait for ordinary commands/characters (50 µs)
- CLR_WAIT, 24000: post-byte wait after rs=0 bytes 0x01/0x02, and after the first init nibble (2 ms)
- PWR_WAIT, 480000: power-on delay before the first init nibble (40 ms)

Ports:
- clk  in  1  system clock, 12 MHz
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  requester N has a byte pending
- req0_rs / req1_rs  in  1  0 = command, 1 = character data
- req0_data / req1_data  in  8  byte to write
- req0_ready / req1_ready  out  1  grant; transfer occurs when valid && ready
- init_done  out  1  init sequence complete (sticky until reset)
- busy  out  1  high unless in IDLE with init_done=1
- rs_out  out  1  LCD RS
- enable_out  out  1  LCD E
- data_out  out  4  LCD DB7..DB4

## Operation
- Reset (async assert, sync release): state=PWR, counter=0, last_grant=1. All outputs 0 except busy=1.
- Counter width: $clog2 of the largest wait parameter, +1.
- States:
  - PWR: count PWR_WAIT cycles, then go to INIT.
  - INIT: walks a fixed ROM. Nibble-only steps, rs=0:
    - 0x3, then wait CLR_WAIT
    - 0x3, then wait CMD_WAIT
    - 0x3, then wait CMD_WAIT
    - 0x2, then wait CMD_WAIT
  - INIT, full bytes, rs=0: 0x28, 0x0C, 0x01 (CLR_WAIT), 0x06.
  - After the last INIT wait, init_done goes to 1 and the FSM enters IDLE.
  - IDLE → SET_HI on a grant.
  - SET_HI (1 cycle): drive rs_out and data_out=data[7:4]; enable=0.
  - EN_HI (EN_HIGH cycles): enable=1.
  - GAP_HI (NIB_GAP cycles): enable=0.
  - SET_LO, EN_LO, GAP_LO: same as the high nibble, with data_out=data[3:0].
  - WAIT: CLR_WAIT if rs=0 and data∈{0x01,0x02}, else CMD_WAIT. Then IDLE.
  - Nibble-only init steps use SET_HI/EN_HI/GAP_HI, then go straight to WAIT.
- Arbitration, IDLE with init_done=1 only:
  - Exactly one valid: that requester is granted.
  - Both valid: grant the requester ≠ last_grant (round-robin).
  - last_grant updates on each accepted transfer.
- Handshake:
  - reqN_ready is combinational: high only in IDLE && init_done && granted(N).
  - At most one ready is high per cycle, and never while busy.
  - rs/data are captured into holding registers on the accept cycle.
  - Requesters hold valid/rs/data stable until ready.
  - Valid dropped before grant: no transfer, no side effect.
- rs_out and data_out change only in SET_* cycles and stay stable through EN_* and GAP_*. Both hold their last value in IDLE/WAIT.
- Reset mid-transfer: enable_out drops asynchronously, the byte is lost, and the init sequence reruns in full.

## Timing
- Accept at cycle T:
  - SET_HI at T+1
  - enable high T+2 .. T+1+EN_HIGH
  - SET_LO at T+2+EN_HIGH+NIB_GAP
- Byte occupancy from T+1 to IDLE: 2·(1+EN_HIGH+NIB_GAP)+wait.
  - Defaults: 650 cycles for normal bytes, 24050 cycles for clear/home.
- Earliest next accept is the first IDLE cycle. There is no bubble beyond that.
- Setup of RS/DB before E rise is 1 cycle (83 ns). Hold after E fall is NIB_GAP cycles.
- init_done rises PWR_WAIT + init ROM time after reset release; busy falls on that same cycle.

## Test plan
- Reset/init: release rst_n → outputs 0 for 480000 cycles. Then the strobed nibble sequence is 3,3,3,2,2,8,0,C,0,1,0,6 with rs=0, and init_done=1 after the final 600-cycle wait. For the bench, shrink parameters, e.g. PWR_WAIT=50, CLR_WAIT=40, CMD_WAIT=10, EN_HIGH=2, NIB_GAP=2.
- Single char: req0 rs=1 data 0x48 → ready0 for 1 cycle. Then nibbles 0x4 then 0x8, rs_out=1, each with E high exactly EN_HIGH cycles, busy for exactly 2·(1+EN_HIGH+NIB_GAP)+CMD_WAIT cycles.
- Clear wait: req1 rs=0 0x01 → post-byte wait = CLR_WAIT. The same byte with rs=1 → CMD_WAIT.
- Round-robin: both valid continuously, req0=0x41, req1=0x42 → grants alternate 0,1,0,1 (req0 first after reset), and ready is never high for both at once.
- Pre-init and busy requests: valid asserted during PWR/INIT or mid-byte → no ready until IDLE. DB/RS are unchanged during EN_* phases.
- Reset mid-byte: assert rst_n low during EN_LO → enable_out=0 in the same cycle. After release, the full init reruns and the aborted byte is never sent.

Source files
------------

// File: rtl/lcd_sched.sv
// lcd_sched: power-on sequencer and two-port byte arbiter for an
// HD44780-class character LCD in 4-bit bus mode.
//
// After reset the block waits PWR_WAIT cycles and then runs the controller
// init ROM. It then accepts byte writes from two requesters, granting them
// round-robin. Each granted byte goes out as two E-strobed nibbles,
// followed by a settle wait.
//
// Handshake (valid/ready): a transfer happens on a rising clk edge where
// reqN_valid && reqN_ready. reqN_ready is combinational and is only high in
// IDLE once init is done, for the requester chosen by the arbiter. A
// requester holds valid/rs/data stable until it sees ready. Dropping valid
// before the grant has no effect.
//
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   reqN_valid/rs/data    byte request (rs: 0 = command, 1 = character)
//   reqN_ready            grant for requester N
//   init_done             init sequence finished (sticky until reset)
//   busy                  high unless idle with init done
//   rs_out, enable_out,
//   data_out[3:0]         LCD RS, E, DB7..DB4
module lcd_sched #(
    parameter int EN_HIGH  = 12,
    parameter int NIB_GAP  = 12,
    parameter int CMD_WAIT = 600,
    parameter int CLR_WAIT = 24000,
    parameter int PWR_WAIT = 480000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       init_done,
    output logic       busy,
    output logic       rs_out,
    output logic       enable_out,
    output logic [3:0] data_out
);

    localparam int MAX_A    = (PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT;
    localparam int MAX_B    = (CMD_WAIT > EN_HIGH) ? CMD_WAIT : EN_HIGH;
    localparam int MAX_C    = (MAX_B > NIB_GAP) ? MAX_B : NIB_GAP;
    localparam int MAX_WAIT = (MAX_A > MAX_C) ? MAX_A : MAX_C;
    localparam int CW       = $clog2(MAX_WAIT) + 1;

    // Terminal counts: a phase lasting N cycles ends when the counter is N-1.
    localparam logic [CW-1:0] PWR_LAST = CW'(PWR_WAIT - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_WAIT - 1);
    localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT - 1);
    localparam logic [CW-1:0] EN_LAST  = CW'(EN_HIGH - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(NIB_GAP - 1);

    typedef enum logic [3:0] {
        S_PWR,
        S_INIT,
        S_IDLE,
        S_SET_HI,
        S_EN_HI,
        S_GAP_HI,
        S_SET_LO,
        S_EN_LO,
        S_GAP_LO,
        S_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    step_q, step_d;
    logic          last_grant_q, last_grant_d;
    logic          init_done_q, init_done_d;
    logic          hold_rs_q, hold_rs_d;
    logic [7:0]    hold_data_q, hold_data_d;
    logic          hold_nib_q, hold_nib_d;
    logic          rs_out_q, rs_out_d;
    logic [3:0]    data_out_q, data_out_d;

    logic          idle_ok;
    logic          grant0;
    logic          grant1;
    logic [CW-1:0] wait_last;
    logic [7:0]    rom_byte;

    // Init ROM. Steps 0..3 are nibble-only (the nibble sits in [7:4]);
    // steps 4..7 are full bytes.
    always_comb begin
        rom_byte = 8'h00;
        case (step_q)
            3'd0:    rom_byte = 8'h30;
            3'd1:    rom_byte = 8'h30;
            3'd2:    rom_byte = 8'h30;
            3'd3:    rom_byte = 8'h20;
            3'd4:    rom_byte = 8'h28;
            3'd5:    rom_byte = 8'h0C;
            3'd6:    rom_byte = 8'h01;
            default: rom_byte = 8'h06;
        endcase
    end

    // Only the first wake-up nibble needs the long wait. Full bytes use the
    // long wait for clear/home commands.
    always_comb begin
        wait_last = CMD_LAST;
        if (hold_nib_q) begin
            if (step_q == 3'd0) wait_last = CLR_LAST;
        end else if (!hold_rs_q && (hold_data_q == 8'h01 || hold_data_q == 8'h02)) begin
            wait_last = CLR_LAST;
        end
    end

    // Round-robin: a lone requester wins. When both are valid, the one not
    // granted last time wins.
    assign idle_ok    = (state_q == S_IDLE) && init_done_q;
    assign grant0     = req0_valid && (!req1_valid || last_grant_q);
    assign grant1     = req1_valid && (!req0_valid || !last_grant_q);
    assign req0_ready = idle_ok && grant0;
    assign req1_ready = idle_ok && grant1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        step_d       = step_q;
        last_grant_d = last_grant_q;
        init_done_d  = init_done_q;
        hold_rs_d    = hold_rs_q;
        hold_data_d  = hold_data_q;
        hold_nib_d   = hold_nib_q;
        rs_out_d     = rs_out_q;
        data_out_d   = data_out_q;

        case (state_q)
            S_PWR: begin
                if (cnt_q == PWR_LAST) begin
                    cnt_d   = '0;
                    step_d  = 3'd0;
                    state_d = S_INIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_INIT: begin
                hold_data_d = rom_byte;
                hold_rs_d   = 1'b0;
                hold_nib_d  = !step_q[2];
                state_d     = S_SET_HI;
            end
            S_IDLE: begin
                if (req0_ready && req0_valid) begin
                    hold_data_d  = req0_data;
                    hold_rs_d    = req0_rs;
                    hold_nib_d   = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = S_SET_HI;
                end else if (req1_ready && req1_valid) begin
                    hold_data_d  = req1_data;
                    hold_rs_d    = req1_rs;
                    hold_nib_d   = 1'b0;
                    last_grant_d = 1'b1;
                    state_d      = S_SET_HI;
                end
            end
            S_SET_HI: begin
                cnt_d   = '0;
                state_d = S_EN_HI;
            end
            S_EN_HI: begin
                if (cnt_q == EN_LAST) begin
                    cnt_d   = '0;
                    state_d = S_GAP_HI;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP_HI: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = hold_nib_q ? S_WAIT : S_SET_LO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SET_LO: begin
                cnt_d   = '0;
                state_d = S_EN_LO;
            end
            S_EN_LO: begin
                if (cnt_q == EN_LAST) begin
                    cnt_d   = '0;
                    state_d = S_GAP_LO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP_LO: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q == wait_last) begin
                    cnt_d = '0;
                    if (init_done_q) begin
                        state_d = S_IDLE;
                    end else if (step_q == 3'd7) begin
                        init_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        step_d  = step_q + 3'd1;
                        state_d = S_INIT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_PWR;
                cnt_d   = '0;
            end
        endcase

        // The bus registers load on entry to a SET state, so RS/DB are valid
        // during the SET cycle and then hold until the next SET.
        if (state_d == S_SET_HI) begin
            rs_out_d   = hold_rs_d;
            data_out_d = hold_data_d[7:4];
        end else if (state_d == S_SET_LO) begin
            data_out_d = hold_data_q[3:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_PWR;
            cnt_q        <= '0;
            step_q       <= 3'd0;
            last_grant_q <= 1'b1;
            init_done_q  <= 1'b0;
            hold_rs_q    <= 1'b0;
            hold_data_q  <= 8'h00;
            hold_nib_q   <= 1'b0;
            rs_out_q     <= 1'b0;
            data_out_q   <= 4'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            step_q       <= step_d;
            last_grant_q <= last_grant_d;
            init_done_q  <= init_done_d;
            hold_rs_q    <= hold_rs_d;
            hold_data_q  <= hold_data_d;
            hold_nib_q   <= hold_nib_d;
            rs_out_q     <= rs_out_d;
            data_out_q   <= data_out_d;
        end
    end

    // E is decoded straight from the state register so it drops with reset.
    assign enable_out = (state_q == S_EN_HI) || (state_q == S_EN_LO);
    assign busy       = !idle_ok;
    assign init_done  = init_done_q;
    assign rs_out     = rs_out_q;
    assign data_out   = data_out_q;

endmodule

// File: tb/tb_lcd_sched.sv
module tb_lcd_sched;
  localparam int EN_HIGH  = 2;
  localparam int NIB_GAP  = 2;
  localparam int CMD_WAIT = 10;
  localparam int CLR_WAIT = 40;
  localparam int PWR_WAIT = 50;
  localparam int BOUND    = 5000;
  localparam int OCC_BASE = 2 * (1 + EN_HIGH + NIB_GAP);

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req0_rs, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_rs, req1_ready;
  logic [7:0] req1_data;
  logic       init_done, busy, rs_out, enable_out;
  logic [3:0] data_out;

  logic [4:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;

  logic [3:0] init_nibs [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                 4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};

  lcd_sched #(
    .EN_HIGH(EN_HIGH), .NIB_GAP(NIB_GAP), .CMD_WAIT(CMD_WAIT),
    .CLR_WAIT(CLR_WAIT), .PWR_WAIT(PWR_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data),
    .req1_ready(req1_ready),
    .init_done(init_done), .busy(busy), .rs_out(rs_out),
    .enable_out(enable_out), .data_out(data_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // monitor: every E strobe is one nibble popped from the scoreboard
  logic       en_prev = 1'b0;
  int         en_len = 0;
  int         strobe_cnt = 0;
  logic [4:0] cap;
  logic [4:0] exp_nib;

  always @(negedge clk) begin
    if (!rst_n) begin
      en_prev = 1'b0;
      en_len  = 0;
    end else begin
      if (req0_ready || req1_ready) begin
        check("ready_excl", {31'd0, req0_ready && req1_ready}, 32'd0);
        check("ready_idle", {30'd0, busy, init_done}, 32'd1);
      end
      if (enable_out && !en_prev) begin
        strobe_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {27'd0, rs_out, data_out}, 32'hFFFF);
        end else begin
          exp_nib = exp_q.pop_front();
          check("nibble", {27'd0, rs_out, data_out}, {27'd0, exp_nib});
        end
        cap    = {rs_out, data_out};
        en_len = 1;
      end else if (enable_out) begin
        en_len++;
        check("db_stable", {27'd0, rs_out, data_out}, {27'd0, cap});
      end else if (en_prev) begin
        check("e_width", en_len, EN_HIGH);
      end
      en_prev = enable_out;
    end
  end

  task automatic push_init();
    for (int i = 0; i < 12; i++) exp_q.push_back({1'b0, init_nibs[i]});
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] d);
    exp_q.push_back({rs, d[7:4]});
    exp_q.push_back({rs, d[3:0]});
  endtask

  // driver: present a byte, wait for grant, optionally measure occupancy
  task automatic send(input int port, input logic rs, input logic [7:0] d,
                      input int occ, input bit measure);
    int n;
    int busy_n;
    if (port == 0) begin
      req0_valid = 1'b1; req0_rs = rs; req0_data = d;
    end else begin
      req1_valid = 1'b1; req1_rs = rs; req1_data = d;
    end
    #1;
    n = 0;
    while (!(port == 0 ? req0_ready : req1_ready) && n < BOUND) begin
      @(negedge clk); #1;
      n++;
    end
    check("grant_timeout", {31'd0, n >= BOUND}, 32'd0);
    if (n < BOUND) begin
      push_byte(rs, d);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (n < BOUND && measure) begin
      busy_n = 0;
      @(negedge clk);
      while (busy && busy_n < BOUND) begin
        busy_n++;
        @(negedge clk);
      end
      check("occupancy", busy_n, occ);
    end
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (!init_done && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("init_timeout", {31'd0, n >= BOUND}, 32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, n >= BOUND}, 32'd0);
  endtask

  initial begin
    int   base;
    int   n;
    int   g;
    logic en_seen;

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_rs = 1'b0; req0_data = 8'h00;
    req1_valid = 1'b0; req1_rs = 1'b0; req1_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_bus", {26'd0, enable_out, rs_out, data_out}, 32'd0);
    check("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);

    // release; a request is pending from the start and must wait for init
    push_init();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h55;
    en_seen = 1'b0;
    for (int i = 0; i < PWR_WAIT; i++) begin
      @(negedge clk);
      en_seen = en_seen | enable_out | rs_out | (|data_out);
    end
    check("pwr_quiet", {31'd0, en_seen}, 32'd0);
    check("pwr_no_init_done", {31'd0, init_done}, 32'd0);
    wait_init();
    check("init_drained", exp_q.size(), 0);
    check("init_busy_low", {31'd0, busy}, 32'd0);

    send(0, 1'b1, 8'h55, OCC_BASE + CMD_WAIT, 1'b1);
    check("init_sticky", {31'd0, init_done}, 32'd1);

    // single char, clear/home waits, plain wait for same byte as data
    send(0, 1'b1, 8'h48, OCC_BASE + CMD_WAIT, 1'b1);
    send(1, 1'b0, 8'h01, OCC_BASE + CLR_WAIT, 1'b1);
    send(1, 1'b1, 8'h01, OCC_BASE + CMD_WAIT, 1'b1);
    send(0, 1'b0, 8'h02, OCC_BASE + CLR_WAIT, 1'b1);
    send(0, 1'b0, 8'h03, OCC_BASE + CMD_WAIT, 1'b1);
    for (int i = 0; i < 3; i++) begin
      logic [7:0] rd;
      rd = 8'($urandom_range(32, 126));
      send(1, 1'b1, rd, OCC_BASE + CMD_WAIT, 1'b1);
    end

    // round-robin with both requesters valid continuously; last grant was 1
    @(negedge clk);
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h41;
    req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h42;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < BOUND) begin
        @(negedge clk); #1;
        n++;
      end
      check("rr_timeout", {31'd0, n >= BOUND}, 32'd0);
      g = req1_ready ? 1 : 0;
      check("rr_grant", g, k % 2);
      push_byte(1'b1, (g == 0) ? 8'h41 : 8'h42);
      @(posedge clk); #1;
      @(negedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();
    check("rr_drained", exp_q.size(), 0);

    // reset during the low-nibble strobe: byte is lost, init reruns
    base = strobe_cnt;
    send(0, 1'b1, 8'h7E, 0, 1'b0);
    n = 0;
    while (strobe_cnt < base + 2 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("lo_strobe_timeout", {31'd0, n >= BOUND}, 32'd0);
    check("abort_e_high", {31'd0, enable_out}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_e_drop", {31'd0, enable_out}, 32'd0);
    check("abort_busy", {30'd0, busy, init_done}, 32'd2);
    check("abort_q", exp_q.size(), 0);
    push_init();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_init();
    repeat (100) @(negedge clk);
    check("rerun_drained", exp_q.size(), 0);
    check("rerun_init_done", {31'd0, init_done}, 32'd1);
    check("rerun_idle", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
